// File: rtl/turn_sequencer.sv
// Turn/hazard indicator sequencer for a bank of NLEDS LEDs: walks a dot or grows a bar
// left/right at a CLK_DIV step rate, and flashes the whole bank NFLASH times on hazard.
module turn_sequencer #(
  parameter int NLEDS   = 8,
  parameter int CLK_DIV = 1,
  parameter int NFLASH  = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_left_stb,
  input  logic             i_right_stb,
  input  logic             i_hazard_stb,
  input  logic             i_fill,
  output logic [NLEDS-1:0] o_led,
  output logic             o_busy
);
  localparam int PW = $clog2(NLEDS);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(2*NFLASH+1);
  localparam logic [PW-1:0]    POS_LAST   = PW'(NLEDS-1);
  localparam logic [DW-1:0]    DIV_LAST   = DW'(CLK_DIV-1);
  localparam logic [FW-1:0]    FLASH_LAST = FW'(2*NFLASH-1);
  localparam logic [NLEDS-1:0] LED_ALL    = {NLEDS{1'b1}};
  localparam logic [NLEDS-1:0] LED_OFF    = {NLEDS{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEFT   = 2'd1,
    S_RIGHT  = 2'd2,
    S_HAZARD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [DW-1:0]    div_q, div_d;
  logic [FW-1:0]    flash_q, flash_d;
  logic             fill_q, fill_d;
  logic [NLEDS-1:0] led_q, led_d;
  logic             busy_q, busy_d;

  logic          stb_l, stb_r, tick, at_end, reverse;
  logic [PW-1:0] pos_step;

  function automatic logic [NLEDS-1:0] led_bit(input logic [PW-1:0] p);
    return NLEDS'(1) << p;
  endfunction

  assign stb_l    = i_left_stb & ~i_right_stb;
  assign stb_r    = i_right_stb & ~i_left_stb;
  assign tick     = (div_q == DIV_LAST);
  // LEFT and RIGHT share one branch; these select the direction-dependent terms
  assign at_end   = (state_q == S_LEFT) ? (pos_q == POS_LAST) : (pos_q == PW'(0));
  assign reverse  = (state_q == S_LEFT) ? stb_r : stb_l;
  assign pos_step = (state_q == S_LEFT) ? (pos_q + PW'(1)) : (pos_q - PW'(1));

  // Next-state and next-pattern logic
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    div_d   = div_q;
    flash_d = flash_q;
    fill_d  = fill_q;
    led_d   = led_q;
    case (state_q)
      S_IDLE: begin
        div_d   = '0;
        flash_d = '0;
        if (i_hazard_stb) begin
          state_d = S_HAZARD;
          led_d   = LED_ALL;
        end else if (stb_l) begin
          state_d = S_LEFT;
          pos_d   = '0;
          fill_d  = i_fill;
          led_d   = led_bit(PW'(0));
        end else if (stb_r) begin
          state_d = S_RIGHT;
          pos_d   = POS_LAST;
          fill_d  = i_fill;
          led_d   = led_bit(POS_LAST);
        end else begin
          led_d   = LED_OFF;
        end
      end
      S_LEFT, S_RIGHT: begin
        if (i_hazard_stb) begin
          state_d = S_HAZARD;
          led_d   = LED_ALL;
          div_d   = '0;
          flash_d = '0;
        end else if (tick && at_end) begin
          state_d = S_IDLE;
          led_d   = LED_OFF;
          div_d   = '0;
        end else if (reverse) begin
          // divider is held so the reversed pattern keeps the remaining hold time
          state_d = (state_q == S_LEFT) ? S_RIGHT : S_LEFT;
          if (fill_q) begin
            led_d = led_bit(pos_q);
          end else begin
            led_d = led_q;
          end
        end else if (tick) begin
          pos_d = pos_step;
          div_d = '0;
          led_d = fill_q ? (led_q | led_bit(pos_step)) : led_bit(pos_step);
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_HAZARD: begin
        if (tick) begin
          div_d = '0;
          if (flash_q == FLASH_LAST) begin
            state_d = S_IDLE;
            led_d   = LED_OFF;
            flash_d = '0;
          end else begin
            led_d   = ~led_q;
            flash_d = flash_q + FW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        led_d   = LED_OFF;
        div_d   = '0;
        flash_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      div_q   <= '0;
      flash_q <= '0;
      fill_q  <= 1'b0;
      led_q   <= LED_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      flash_q <= flash_d;
      fill_q  <= fill_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;

  turn_sequencer_chk #(.NLEDS(NLEDS), .PW(PW)) u_chk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_state (state_q),
    .i_pos   (pos_q),
    .i_led   (led_q),
    .i_busy  (busy_q),
    .i_fill  (fill_q)
  );
endmodule

// Invariant checker for turn_sequencer registered state.
module turn_sequencer_chk #(
  parameter int NLEDS = 8,
  parameter int PW    = 3
) (
  input logic             i_clk,
  input logic             i_reset,
  input logic [1:0]       i_state,
  input logic [PW-1:0]    i_pos,
  input logic [NLEDS-1:0] i_led,
  input logic             i_busy,
  input logic             i_fill
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic             armed_q;
  logic             walking_s;
  logic [NLEDS-1:0] bit_s, below_s, above_s;

  // A single contiguous run of ones (or zero) leaves nothing after adding its lowest bit
  function automatic logic is_run(input logic [NLEDS-1:0] x);
    logic [NLEDS-1:0] low;
    low = x & (~x + NLEDS'(1));
    return (x & (x + low)) == '0;
  endfunction

  assign walking_s = (i_state == ST_LEFT) || (i_state == ST_RIGHT);
  assign bit_s     = NLEDS'(1) << i_pos;
  assign below_s   = bit_s - NLEDS'(1);
  assign above_s   = ~((bit_s << 1) - NLEDS'(1));

  // Checks start one cycle after the first reset so register contents are defined
  always_ff @(posedge i_clk) begin
    armed_q <= armed_q | i_reset;
  end

  always @(posedge i_clk) begin
    if (armed_q) begin
      a_busy:  assert (i_busy == (i_state != ST_IDLE));
      a_idle:  assert ((i_state != ST_IDLE) || (i_led == '0));
      a_state: assert (i_state inside {2'd0, 2'd1, 2'd2, 2'd3});
      if (walking_s) begin
        a_nz:   assert (i_led != '0);
        a_pos:  assert ((i_led & bit_s) != '0);
        a_walk: assert (i_fill || $onehot0(i_led));
        a_run:  assert (!i_fill || is_run(i_led));
        a_left: assert (!i_fill || (i_state != ST_LEFT)  || ((i_led & above_s) == '0));
        a_rght: assert (!i_fill || (i_state != ST_RIGHT) || ((i_led & below_s) == '0));
      end
    end
  end
endmodule

// File: tb/tb_turn_sequencer.sv
// Bench for turn_sequencer: two instances (CLK_DIV=1 and CLK_DIV=2) share stimulus and are
// checked against directed vectors and against a cycle-level behavioural model.
module tb_turn_sequencer;
  localparam int N  = 8;
  localparam int NF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sl, sr, sh, sf;
  logic [N-1:0] led0, led1;
  logic busy0, busy1;

  turn_sequencer #(.NLEDS(N), .CLK_DIV(1), .NFLASH(NF)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_left_stb(sl), .i_right_stb(sr),
    .i_hazard_stb(sh), .i_fill(sf), .o_led(led0), .o_busy(busy0));

  turn_sequencer #(.NLEDS(N), .CLK_DIV(2), .NFLASH(NF)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_left_stb(sl), .i_right_stb(sr),
    .i_hazard_stb(sh), .i_fill(sf), .o_led(led1), .o_busy(busy1));

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 walking, 2 hazard; a fill bar spans anchor..pos
  int m_mode[2], m_pos[2], m_dir[2], m_anchor[2], m_age[2], m_phase[2];
  bit m_fill[2];
  int divs[2] = '{1, 2};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_led(input int k);
    logic [N-1:0] v;
    int lo, hi;
    v  = '0;
    lo = (m_anchor[k] < m_pos[k]) ? m_anchor[k] : m_pos[k];
    hi = (m_anchor[k] < m_pos[k]) ? m_pos[k] : m_anchor[k];
    if (m_mode[k] == 2) begin
      v = (m_phase[k] % 2 == 0) ? '1 : '0;
    end else if (m_mode[k] == 1) begin
      for (int b = 0; b < N; b++)
        if (m_fill[k] ? (b >= lo && b <= hi) : (b == m_pos[k])) v[b] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_step(input int k, input logic rs, l, r, h, f);
    bit lft, rgt, due, at_end;
    lft    = l && !r;
    rgt    = r && !l;
    due    = (m_age[k] == divs[k] - 1);
    at_end = (m_dir[k] > 0) ? (m_pos[k] == N - 1) : (m_pos[k] == 0);
    if (rs) begin
      m_mode[k] = 0; m_pos[k] = 0; m_age[k] = 0; m_phase[k] = 0;
      m_anchor[k] = 0; m_fill[k] = 0; m_dir[k] = 1;
    end else if (m_mode[k] == 0) begin
      if (h) begin
        m_mode[k] = 2; m_phase[k] = 0; m_age[k] = 0;
      end else if (lft || rgt) begin
        m_mode[k] = 1; m_dir[k] = lft ? 1 : -1; m_pos[k] = lft ? 0 : N - 1;
        m_anchor[k] = m_pos[k]; m_fill[k] = f; m_age[k] = 0;
      end
    end else if (m_mode[k] == 1) begin
      if (h) begin
        m_mode[k] = 2; m_phase[k] = 0; m_age[k] = 0;
      end else if (due && at_end) begin
        m_mode[k] = 0; m_age[k] = 0;
      end else if ((m_dir[k] > 0 && rgt) || (m_dir[k] < 0 && lft)) begin
        m_dir[k] = -m_dir[k]; m_anchor[k] = m_pos[k];
      end else if (due) begin
        m_pos[k] += m_dir[k]; m_age[k] = 0;
      end else begin
        m_age[k]++;
      end
    end else begin
      if (due) begin
        m_phase[k]++; m_age[k] = 0;
        if (m_phase[k] == 2 * NF) m_mode[k] = 0;
      end else begin
        m_age[k]++;
      end
    end
  endtask

  // One clock: drive, advance model, sample #1 after the edge, compare both instances
  task automatic step(input logic rs, l, r, h, f);
    rst = rs; sl = l; sr = r; sh = h; sf = f;
    @(posedge clk);
    model_step(0, rs, l, r, h, f);
    model_step(1, rs, l, r, h, f);
    #1;
    check("model0_led",  32'(led0),  32'(model_led(0)));
    check("model0_busy", 32'(busy0), 32'(m_mode[0] != 0));
    check("model1_led",  32'(led1),  32'(model_led(1)));
    check("model1_busy", 32'(busy1), 32'(m_mode[1] != 0));
  endtask

  typedef struct {
    logic rs, l, r, h, f;
    int   dut;
    logic [N-1:0] led;
    logic busy;
  } vec_t;
  vec_t vecs[$];

  // code: 0 none, 1 L, 2 R, 3 hazard, 4 L+R, 5 reset, 6 reset+R; dut -1 = model check only
  task automatic add(input int code, input logic f, input int d, input logic [N-1:0] e, input logic eb);
    vec_t v;
    v.rs = (code == 5 || code == 6);
    v.l  = (code == 1 || code == 4);
    v.r  = (code == 2 || code == 4 || code == 6);
    v.h  = (code == 3);
    v.f  = f; v.dut = d; v.led = e; v.busy = eb;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add(0, 1'b0, -1, 8'h00, 1'b0);
  endtask

  initial begin
    logic [N-1:0] seq_w [9];
    logic [N-1:0] seq_f [9];
    logic [N-1:0] seq_h [18];
    int           cod_h [18];
    logic [N-1:0] seq_r [7];
    int           cod_r [7];
    logic [N-1:0] e;
    int cnt0, cnt1;

    rst = 1'b1; sl = 1'b0; sr = 1'b0; sh = 1'b0; sf = 1'b0;
    seq_w = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    seq_f = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h08, 8'h0C, 8'h0E, 8'h0F, 8'h00};
    cod_h = '{1, 0, 0, 0, 0, 3, 1, 0, 2, 0, 3, 0, 1, 0, 0, 0, 0, 0};
    seq_h = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'hFF, 8'hFF, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    cod_r = '{1, 0, 6, 0, 0, 2, 0};
    seq_r = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'h40};

    // reset state
    add(5, 1'b0, 0, 8'h00, 1'b0);
    add(5, 1'b0, 1, 8'h00, 1'b0);
    // CLK_DIV=2 walking left: each LED held two cycles, busy for 16
    for (int k = 0; k < 16; k++) add((k == 0) ? 1 : 0, 1'b0, 1, 8'(1 << (k / 2)), 1'b1);
    add(0, 1'b0, 1, 8'h00, 1'b0);
    add_idle(20);
    // CLK_DIV=1 bar growing right, fill input toggled after the start
    add(2, 1'b1, 0, 8'h80, 1'b1);
    for (int k = 1; k < 8; k++) begin
      e = 8'hFF >> (k + 1);
      add(0, 1'(k % 2), 0, ~e, 1'b1);
    end
    add(0, 1'b1, 0, 8'h00, 1'b0);
    add_idle(20);
    // reversal at 08, walk then fill
    for (int k = 0; k < 9; k++) add((k == 0) ? 1 : (k == 4) ? 2 : 0, 1'b0, 0, seq_w[k], 1'(k < 8));
    add_idle(20);
    for (int k = 0; k < 9; k++) add((k == 0) ? 1 : (k == 4) ? 2 : 0, 1'(k == 0), 0, seq_f[k], 1'(k < 8));
    add_idle(20);
    // simultaneous L+R in idle, then a same-direction strobe mid-walk
    add(4, 1'b0, 0, 8'h00, 1'b0);
    add(0, 1'b0, 1, 8'h00, 1'b0);
    for (int k = 0; k < 9; k++) add((k == 0 || k == 2) ? 1 : 0, 1'b0, 0, (k < 8) ? 8'(1 << k) : 8'h00, 1'(k < 8));
    add_idle(20);
    // reversal strobe on the terminal tick is dropped
    for (int k = 0; k < 9; k++) add((k == 0) ? 1 : (k == 8) ? 2 : 0, 1'b0, 0, (k < 8) ? 8'(1 << k) : 8'h00, 1'(k < 8));
    add(0, 1'b0, 0, 8'h00, 1'b0);
    add_idle(20);
    // hazard preempting a CLK_DIV=2 walk, with ignored strobes during the flash
    for (int k = 0; k < 18; k++) add(cod_h[k], 1'b0, 1, seq_h[k], 1'(k < 17));
    add_idle(20);
    // reset together with a right strobe mid-walk
    for (int k = 0; k < 7; k++) add(cod_r[k], 1'b0, 0, seq_r[k], 1'(k != 2 && k != 3 && k != 4));
    add_idle(20);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rs, vecs[i].l, vecs[i].r, vecs[i].h, vecs[i].f);
      if (vecs[i].dut == 0) begin
        check($sformatf("vec%0d_led0", i),  32'(led0),  32'(vecs[i].led));
        check($sformatf("vec%0d_busy0", i), 32'(busy0), 32'(vecs[i].busy));
      end else if (vecs[i].dut == 1) begin
        check($sformatf("vec%0d_led1", i),  32'(led1),  32'(vecs[i].led));
        check($sformatf("vec%0d_busy1", i), 32'(busy1), 32'(vecs[i].busy));
      end
    end

    // hazard length from idle: 2*NFLASH*CLK_DIV busy cycles on each instance
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cnt0 = 0;
    cnt1 = 0;
    while (busy1 === 1'b1 && cnt1 < 100) begin
      cnt1++;
      if (busy0 === 1'b1) cnt0++;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("hazard_len_div1", 32'(cnt0), 32'(2 * NF * 1));
    check("hazard_len_div2", 32'(cnt1), 32'(2 * NF * 2));

    // random strobes against the model
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Parametrised vehicle turn/hazard indicator driving a bank of NLEDS LEDs.
- Left/right strobes walk a single LED, or grow a bar, across the bank at a programmable step rate. A mid-walk opposite strobe reverses direction.
- A hazard strobe flashes the whole bank a fixed number of times.
- Sits between the debounced button strobes and the board LED pins.

Parameters:
NLEDS, 8, number of LEDs (>=2)
CLK_DIV, 1, clock cycles each LED pattern is held (>=1)
NFLASH, 3, number of on/off flash pairs in hazard mode (>=1)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_left_stb  input  1  left button strobe, one-cycle pulse
i_right_stb  input  1  right button strobe, one-cycle pulse
i_hazard_stb  input  1  hazard button strobe, one-cycle pulse
i_fill  input  1  mode at start of walk: 0 = single walking LED, 1 = cumulative bar
o_led  output  NLEDS  LED drive, bit 0 = rightmost
o_busy  output  1  registered; high whenever state != IDLE

Behaviour:
- Reset (i_reset high at clock edge; overrides all strobes that cycle):
  - state = IDLE, o_led = 0, o_busy = 0.
  - pos, divider, flash count and latched mode all = 0.
- Strobe decode:
  - L = i_left_stb & !i_right_stb; R = i_right_stb & !i_left_stb.
  - Both or neither of left/right = no strobe.
  - i_hazard_stb has priority over L/R in every state.
- States: IDLE, LEFT, RIGHT, HAZARD. Response latency to any strobe is 1 cycle (o_led/o_busy valid the following cycle).
- Step tick:
  - divider counts 0..CLK_DIV-1 while state != IDLE; tick = (divider == CLK_DIV-1).
  - divider is cleared on every entry from IDLE or into HAZARD.
  - Net effect: every pattern is held exactly CLK_DIV cycles.
- IDLE:
  - hazard -> HAZARD, o_led = all ones, flash count = 0.
  - else L -> LEFT, pos = 0, o_led = bit 0.
  - else R -> RIGHT, pos = NLEDS-1, o_led = bit NLEDS-1.
  - i_fill is latched on entry to LEFT/RIGHT; later changes are ignored until the next start.
- LEFT, on tick:
  - If pos == NLEDS-1 -> IDLE, o_led = 0.
  - Else pos+1. Walk mode: o_led = 1<<(pos+1). Fill mode: o_led |= 1<<(pos+1).
- RIGHT: mirror of LEFT. Terminates at pos == 0; otherwise pos-1.
- Reversal:
  - Trigger: R while in LEFT (or L while in RIGHT), on any cycle.
  - Switch direction next cycle; pos and divider unchanged.
  - Walk mode: o_led unchanged. Fill mode: o_led = 1<<pos (bar restarts from the current LED).
  - The next tick steps in the new direction.
- Same-direction strobe while walking is ignored.
- Terminal tick coincident with a reversal strobe: termination wins -> IDLE, strobe dropped.
- Hazard strobe in LEFT/RIGHT preempts: -> HAZARD, o_led = all ones, divider and flash count = 0.
- HAZARD:
  - On each tick, o_led toggles between all ones and 0, and flash count increments.
  - After 2*NFLASH phases (the final phase is off) -> IDLE with o_led = 0.
  - L/R strobes and repeated hazard strobes are ignored.
- Widths:
  - pos = $clog2(NLEDS).
  - divider = max(1, $clog2(CLK_DIV)).
  - flash count = $clog2(2*NFLASH+1).
- Invariants (to be asserted):
  - o_busy == (state != IDLE).
  - In LEFT/RIGHT: o_led != 0 and bit pos set.
  - Walk mode: at most one bit set.
  - Fill mode: o_led is a contiguous run of ones ending at pos.
  - IDLE implies o_led == 0.
  - No state encoding other than the four listed.

Test Plan:
- NLEDS=8, CLK_DIV=2, i_fill=0, left pulse -> o_led 01,01,02,02,04,04,...,80,80 then 00. o_busy high for exactly 16 cycles.
- CLK_DIV=1, i_fill=1, right pulse -> o_led 80,C0,E0,F0,F8,FC,FE,FF then 00. Toggling i_fill mid-walk does not change the sequence.
- CLK_DIV=1, walk mode, left pulse; right pulse while o_led=08 -> 08,04,02,01,00. In fill mode the same stimulus gives 08,0C,0E,0F,00.
- Left+right same cycle in IDLE -> o_led stays 00, o_busy 0. Extra left pulse during a left walk -> sequence identical to the unperturbed run.
- CLK_DIV=2, NFLASH=3, hazard pulse while o_led=04 -> FF,FF,00,00 repeated 3 times, then IDLE. Left/right pulses during hazard have no effect.
- Reset pulsed mid-walk together with a right strobe -> next cycle o_led=00, o_busy=0. The bench then sees no walk start until a new strobe arrives.
